// File: rtl/sdf_stage_ctrl.sv
// Control for one single-path delay-feedback NTT/FFT stage.
// Tracks frame position, butterfly phase, twiddle index and output timing.
module sdf_stage_ctrl #(
   parameter int N     = 256,
   parameter int DELAY = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 bf_sel,
   output logic [$clog2(N)-1:0] tw_addr,
   output logic                 out_valid,
   output logic                 out_last,
   output logic                 busy,
   output logic                 err
);

   localparam int AW = $clog2(N);
   localparam int BW = $clog2(2 * DELAY);
   localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [AW-1:0] LASTI = AW'(N - 1);
   localparam logic [DW-1:0] DLOAD = DW'(DELAY - 1);
   localparam logic [AW-1:0] TWBASE = AW'(N / (2 * DELAY));

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] icnt_q, icnt_d;
   logic          act_q, act_d;
   logic          rise_q, rise_d;
   logic [DW-1:0] rcnt_q, rcnt_d;
   logic          fall_q, fall_d;
   logic [DW-1:0] fcnt_q, fcnt_d;

   logic viol;
   logic acc;
   logic rise_hit;
   logic fall_hit;

   // Inputs arrive in contiguous runs, so the delayed stream is fully
   // described by one pending start and one pending end countdown.
   always_comb begin
      viol = ((state_q == RUN) && !in_valid)
          || (in_valid && in_last && (icnt_q != LASTI))
          || (in_valid && !in_last && (icnt_q == LASTI));
      acc      = in_valid && !viol;
      rise_hit = rise_q && (rcnt_q == '0);
      fall_hit = fall_q && (fcnt_q == '0);

      bf_sel    = in_valid && icnt_q[BW-1];
      tw_addr   = bf_sel ? (TWBASE + (icnt_q >> BW)) : '0;
      out_valid = act_q || rise_hit;
      out_last  = fall_hit;
      busy      = (state_q != IDLE);
      err       = viol && !rst;

      state_d = state_q;
      icnt_d  = icnt_q;
      act_d   = act_q;
      rise_d  = rise_q;
      rcnt_d  = rcnt_q;
      fall_d  = fall_q;
      fcnt_d  = fcnt_q;

      if (rise_hit) begin
         act_d  = 1'b1;
         rise_d = 1'b0;
      end else if (rise_q) begin
         rcnt_d = rcnt_q - 1'b1;
      end

      if (fall_hit) begin
         act_d  = 1'b0;
         fall_d = 1'b0;
      end else if (fall_q) begin
         fcnt_d = fcnt_q - 1'b1;
      end

      if (acc) begin
         icnt_d = icnt_q + 1'b1;
         if (icnt_q == '0) begin
            rise_d = 1'b1;
            rcnt_d = DLOAD;
         end
         if (in_last) begin
            fall_d  = 1'b1;
            fcnt_d  = DLOAD;
            state_d = DRAIN;
         end else begin
            state_d = RUN;
         end
      end else if ((state_q == DRAIN) && fall_hit) begin
         state_d = IDLE;
      end

      if (viol) begin
         state_d = IDLE;
         icnt_d  = '0;
         act_d   = 1'b0;
         rise_d  = 1'b0;
         rcnt_d  = '0;
         fall_d  = 1'b0;
         fcnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         icnt_q  <= '0;
         act_q   <= 1'b0;
         rise_q  <= 1'b0;
         rcnt_q  <= '0;
         fall_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         icnt_q  <= icnt_d;
         act_q   <= act_d;
         rise_q  <= rise_d;
         rcnt_q  <= rcnt_d;
         fall_q  <= fall_d;
         fcnt_q  <= fcnt_d;
      end
   end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, meaning coefficients per polynomial frame (power of two).
REQ-002 SHALL have parameter DELAY, default 128, meaning depth of the controlled delay fifo (power of two, 1 <= DELAY <= N/2).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  coefficient presented and accepted this cycle (no backpressure).
REQ-006 SHALL have port in_last  input  1  qualifies in_valid; marks coefficient N-1 of a frame.
REQ-007 SHALL have port bf_sel  output  1  1 = butterfly phase; 0 = fill/pass phase.
REQ-008 SHALL have port tw_addr  output  $clog2(N)  twiddle ROM index for the current butterfly.
REQ-009 SHALL have port out_valid  output  1  stage output coefficient valid this cycle.
REQ-010 SHALL have port out_last  output  1  qualifies out_valid; last output coefficient of a frame.
REQ-011 SHALL have port busy  output  1  frame accepted or outputs pending.
REQ-012 SHALL have port err  output  1  one-cycle pulse on frame protocol violation.

Function
REQ-013 SHALL keep an input index icnt (0..N-1), incremented on each accepted coefficient, wrapping N-1 -> 0.
REQ-014 SHALL drive bf_sel = 1 combinationally iff in_valid and (icnt mod 2*DELAY) >= DELAY; else 0.
REQ-015 SHALL drive tw_addr = N/(2*DELAY) + icnt/(2*DELAY) while bf_sel = 1, and 0 otherwise.
REQ-016 SHALL assert out_valid at cycle t iff a coefficient was accepted at cycle t-DELAY and no abort (REQ-020) or reset occurred in between; fixed latency DELAY, no dependence on fifo contents.
REQ-017 SHALL assert out_last at cycle t iff the coefficient accepted at t-DELAY carried in_last.
REQ-018 SHALL use states IDLE (icnt = 0, nothing pending), RUN (0 < icnt, frame in progress), DRAIN (frame complete, outputs pending); IDLE->RUN on in_valid, RUN->DRAIN on accepted in_last, DRAIN->IDLE after last pending out_valid, DRAIN->RUN on in_valid.
REQ-019 SHALL accept a new frame while in DRAIN (back-to-back frames), producing a gap-free out_valid stream across the frame boundary.
REQ-020 SHALL, on violation, pulse err for one cycle, clear icnt and all pending outputs, force out_valid = 0 from the next cycle, and enter IDLE; violations: in_valid = 0 in RUN; in_last with icnt != N-1; in_valid without in_last at icnt = N-1.
REQ-021 SHALL drop the coefficient on the violating cycle (not counted, never output).
REQ-022 SHALL ignore in_last when in_valid = 0.
REQ-023 SHALL drive busy = 1 whenever state != IDLE.
REQ-024 SHALL implement the delay tracking with counters and at most one pending-frame record, not a DELAY-deep valid shift register when DELAY > 8.

Reset
REQ-025 SHALL, when rst = 1 at a rising edge, set state IDLE, icnt 0, all pending outputs cleared; at the next cycle bf_sel, tw_addr, out_valid, out_last, busy, err all = 0.
REQ-026 SHALL let rst override all other inputs, including mid-frame and during DRAIN; no err pulse on reset.
REQ-027 SHALL accept in_valid on the first cycle after rst deasserts.

Verification (N=16, DELAY=4)
REQ-028 Single frame: 16 contiguous in_valid, in_last on 16th -> bf_sel pattern 0000 1111 0000 1111; tw_addr 2,2,2,2 then 3,3,3,3 in bf_sel cycles; out_valid cycles 4..19 after first input; out_last at cycle 19; busy falls cycle 20.
REQ-029 Back-to-back: second frame starts the cycle after first in_last -> out_valid continuous for 32 cycles; out_last at cycles 19 and 35; no err.
REQ-030 Gap: in_valid low at icnt = 7 -> err pulse that cycle; out_valid 0 from next cycle; state IDLE; busy 0.
REQ-031 Early last: in_last at icnt = 9 -> err pulse; coefficient dropped; subsequent clean frame processes normally.
REQ-032 Missing last: in_valid without in_last at icnt = 15 -> err pulse; IDLE.
REQ-033 Reset mid-DRAIN: rst at cycle 17 of REQ-028 -> out_valid/out_last 0 thereafter, busy 0, err never asserted.
